// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared constants and state encoding for the memory access unit
package mem_access_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;

    localparam logic [1:0] BANK_INSTR = 2'b00;
    localparam logic [1:0] BANK_D1    = 2'b01;
    localparam logic [1:0] BANK_D2    = 2'b10;
    localparam logic [1:0] BANK_D3    = 2'b11;

    localparam int BANK_HI = 11;
    localparam int BANK_LO = 10;
    localparam int WORD_HI = 9;
    localparam int WORD_LO = 1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RD_ADDR = 3'd1;
    localparam state_t ST_RD_DATA = 3'd2;
    localparam state_t ST_WRITE   = 3'd3;
    localparam state_t ST_ERR     = 3'd4;

endpackage

// File: rtl/mem_bus_driver.sv
// rtl/mem_bus_driver.sv - tri-state data bus driver with captured read register
module mem_bus_driver #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              oe,
    input  logic [DATA_W-1:0] wdata,
    input  logic              capture,
    output logic [DATA_W-1:0] rdata,
    inout  wire  [DATA_W-1:0] data_bus
);

    assign data_bus = oe ? wdata : {DATA_W{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (capture) begin
            rdata <= data_bus;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-word load/store bus initiator; MEM_ACCESS_ALIGN_CHECK_EN enables misalignment errors
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] address_bus,
    inout  wire  [DATA_W-1:0] data_bus,
    output logic              write_mode
);

    // Byte addresses map to 16-bit words, so bit 0 never reaches the memory.
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(1);

    state_t            state;
    logic [DATA_W-1:0] wdata_q;
    logic              accept;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid & req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            address_bus <= '0;
            write_mode  <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            wdata_q     <= '0;
        end else begin
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            write_mode <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
                        if (req_addr[0]) begin
                            state <= ST_ERR;
                        end else begin
                            address_bus <= req_addr & WORD_MASK;
                            wdata_q     <= req_wdata;
                            write_mode  <= req_write;
                            state       <= req_write ? ST_WRITE : ST_RD_ADDR;
                        end
`else
                        address_bus <= req_addr & WORD_MASK;
                        wdata_q     <= req_wdata;
                        write_mode  <= req_write;
                        state       <= req_write ? ST_WRITE : ST_RD_ADDR;
`endif
                    end
                end
                ST_RD_ADDR: state <= ST_RD_DATA;
                ST_RD_DATA: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b1;
                end
                ST_WRITE: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b1;
                end
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
                ST_ERR: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The registered write_mode doubles as the bus output enable.
    mem_bus_driver #(.DATA_W(DATA_W)) u_bus (
        .clk      (clk),
        .rst_n    (rst_n),
        .oe       (write_mode),
        .wdata    (wdata_q),
        .capture  (state == ST_RD_DATA),
        .rdata    (rsp_rdata),
        .data_bus (data_bus)
    );

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Bus initiator for the unified 4 KB data/instruction memory. It accepts single-word load/store requests from the CPU datapath over a valid/ready handshake and drives the memory's shared address bus, bidirectional data bus and write-mode strobe. It returns load data or store completion on a one-cycle response pulse. It sits between the CPU execute stage and the memory's data port; instruction fetch is out of scope.

## Interface
- ADDR_W, 12, byte address width; bits [11:10] select the 1 KB bank, bits [9:1] select the 16-bit word.
- DATA_W, 16, word width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high exactly in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  load data; holds its value between loads.
- rsp_err  out  1  qualifies rsp_valid; misaligned request.
- address_bus  out  ADDR_W  to memory.
- data_bus  inout  DATA_W  driven only while write_mode=1, otherwise high-Z.
- write_mode  out  1  registered; 1 = memory write, 0 = memory read.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WRITE, ERR.
- IDLE: on req_valid & req_ready, latch addr, wdata and write.
  - Misaligned (addr[0]=1, checker enabled): go to ERR.
  - req_write=1: go to WRITE.
  - Otherwise: go to RD_ADDR.
- RD_ADDR: address_bus = latched addr, write_mode=0. The memory registers the word at the closing edge. Go to RD_DATA.
- RD_DATA: address held. Sample data_bus into rsp_rdata at the closing edge, set rsp_valid=1 and rsp_err=0 for the next cycle. Go to IDLE.
- WRITE: address_bus = addr, write_mode=1, data_bus = wdata. The memory commits at the closing edge. Pulse rsp_valid with rsp_err=0. Go to IDLE.
- ERR: no bus activity, write_mode stays 0. Pulse rsp_valid with rsp_err=1. rsp_rdata is unchanged. Go to IDLE.
- Bank 00 (instruction bank) is writable. No protection is applied.
- Response and acceptance may coincide: in the cycle rsp_valid=1 the unit is in IDLE and may accept the next request.
- The data_bus output enable is the write_mode register itself, so drive and release switch together. There is no dead cycle.

## Timing
- Reset values (asynchronous):
  - State IDLE, req_ready=1.
  - address_bus=0, write_mode=0, data_bus high-Z.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Load: with accept edge E0, rsp_valid is high between E2 and E3. Back-to-back loads run at 3 cycles each.
- Store and error: rsp_valid is high between E1 and E2. Back-to-back stores run at 2 cycles each.
- In IDLE, address_bus keeps its last value and write_mode=0. The memory's idle reads are harmless.
- Reset during WRITE: write_mode drops immediately. The store is committed only if a clock edge occurred with write_mode=1. No response is issued.
- Reset during a read: the read is aborted with no response.
- req_* are don't-care outside the accept cycle.

## Configuration
- MEM_ACCESS_ALIGN_CHECK_EN
  - Defined: addr[0]=1 goes to ERR with rsp_err=1 and no memory access.
  - Undefined: addr[0] is forced to 0 on address_bus, rsp_err is tied 0, and ERR is not compiled.

## Structure
- Package mem_access_pkg contains:
  - the state enum;
  - ADDR_W/DATA_W defaults;
  - bank-select constants BANK_INSTR=2'b00, BANK_D1..BANK_D3;
  - the word-index slice bounds [9:1].
- One sub-module, mem_bus_driver: a tri-state data_bus driver with an output-enable input (write_mode) and a captured-read path.

## Test plan
- Preload the word at 0xFFC with 0xABCD, then load 0xFFC: rsp_rdata=0xABCD, rsp_err=0, rsp_valid exactly 2 edges after accept.
- Store 0x1234 to 0x400, then load 0x400: rsp_rdata=0x1234. write_mode is high for exactly one cycle and data_bus is high-Z before and after.
- Load 0x401:
  - With MEM_ACCESS_ALIGN_CHECK_EN: rsp_err=1, write_mode never rises, rsp_rdata unchanged.
  - Without it: returns the word at 0x400.
- Hold req_valid high for load, store, load: each accept happens in the rsp_valid cycle of the previous request, 8 cycles total, and all data is correct.
- Assert rst_n=0 mid-WRITE: write_mode=0 and data_bus high-Z immediately, no rsp_valid, req_ready=1 after release.
- Store 0x5555 to 0x000 (instruction bank), then load: returns 0x5555.
